// File: rtl/pipe_rca_if.sv
// pipe_rca_if: operand/result handshake bundle for the pipelined adder.
// slave is the adder side, master is the producer/consumer side.
interface pipe_rca_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined signed ripple-carry adder, SEG_W bits rippled per stage.
// Each stage carries forward only the operand bits still to be added and the
// sum bits produced so far. One global stall freezes every stage while the
// output is held. Optional saturation on signed overflow: PIPE_RCA_SAT_EN.
module pipe_rca #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  pipe_rca_if.slave bus
);
  localparam int NSEG = WIDTH / SEG_W;

  logic advance;

  // The whole pipe moves unless a finished result is waiting on the consumer.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  genvar gi;
  for (gi = 0; gi < NSEG; gi++) begin : g_stage
    localparam int LO = gi * SEG_W;
    localparam int HI = (gi + 1) * SEG_W;

    logic [SEG_W-1:0] a_seg;
    logic [SEG_W-1:0] b_seg;
    logic             c_in;
    logic             v_in;
    logic [SEG_W:0]   seg_add;
    logic [HI-1:0]    sum_raw;
    logic [HI-1:0]    sum_d;
    logic [HI-1:0]    sum_q;
    logic             valid_q;
    logic             carry_q;

    // Stage inputs come from the bus for stage 0, otherwise from the previous stage.
    if (gi == 0) begin : g_src
      assign a_seg   = bus.a[SEG_W-1:0];
      assign b_seg   = bus.b[SEG_W-1:0];
      assign c_in    = bus.cin;
      assign v_in    = bus.in_valid;
      assign sum_raw = seg_add[SEG_W-1:0];
    end else begin : g_src
      assign a_seg   = g_stage[gi-1].g_fwd.opa_q[SEG_W-1:0];
      assign b_seg   = g_stage[gi-1].g_fwd.opb_q[SEG_W-1:0];
      assign c_in    = g_stage[gi-1].carry_q;
      assign v_in    = g_stage[gi-1].valid_q;
      assign sum_raw = {seg_add[SEG_W-1:0], g_stage[gi-1].sum_q};
    end

    assign seg_add = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};

    // Shift the token every advance; data only follows a valid token.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (advance) begin
        valid_q <= v_in;
        if (v_in) begin
          sum_q   <= sum_d;
          carry_q <= seg_add[SEG_W];
        end
      end
    end

    if (gi < NSEG - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] opa_d;
      logic [WIDTH-HI-1:0] opb_d;
      logic [WIDTH-HI-1:0] opa_q;
      logic [WIDTH-HI-1:0] opb_q;

      if (gi == 0) begin : g_op
        assign opa_d = bus.a[WIDTH-1:HI];
        assign opb_d = bus.b[WIDTH-1:HI];
      end else begin : g_op
        assign opa_d = g_stage[gi-1].g_fwd.opa_q[WIDTH-LO-1:SEG_W];
        assign opb_d = g_stage[gi-1].g_fwd.opb_q[WIDTH-LO-1:SEG_W];
      end

      assign sum_d = sum_raw;

      // Carry the not-yet-added upper operand bits down the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (advance && v_in) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^s of the MSB column.
      assign ovf_d = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ seg_add[SEG_W-1] ^ seg_add[SEG_W];

`ifdef PIPE_RCA_SAT_EN
      // Clamp toward the operands' common sign on overflow.
      always_comb begin
        sum_d = sum_raw;
        if (ovf_d) begin
          sum_d = a_seg[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign sum_d = sum_raw;
`endif

      // Overflow flag is registered alongside the final sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSEG-1].valid_q;
  assign bus.sum       = g_stage[NSEG-1].sum_q;
  assign bus.cout      = g_stage[NSEG-1].carry_q;
  assign bus.ovf       = g_stage[NSEG-1].g_last.ovf_q;
endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined signed ripple-carry adder for the FIR filter datapath, succeeding the fixed 8-bit combinational adder. Operands are split into SEG_W-bit segments. Each pipeline stage ripples one segment and registers the carry and the not-yet-added operand bits, so throughput is one add per clock at any WIDTH. A valid/ready handshake with full-pipeline backpressure lets it sit between the tap multipliers and the accumulator. Signed overflow is detected, and saturation is optional.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG_W.
- SEG_W, 4, bits rippled per pipeline stage; NSEG = WIDTH/SEG_W stages.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  adder accepts operands this cycle
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  signed result
- cout  output  1  carry out of the MSB, always the raw value
- ovf  output  1  signed overflow flag

## Operation
- Stage k (0..NSEG-1) adds bits [k*SEG_W +: SEG_W] of A and B plus the carry from stage k-1. Stage 0 uses cin.
- Each stage registers: its valid bit, the sum bits computed so far, the carry, and the upper operand bits still to be added.
- The last stage registers the full sum and cout. It also registers ovf = carry into MSB XOR carry out of MSB.
- The result equals (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH of the unsigned sum.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready.
  - While advance = 0, every stage register holds its value.
  - in_ready = advance, a combinational function of out_valid and out_ready only.
- No bubble collapsing. A stage with valid = 0 still shifts when advance = 1.
- Inputs a, b and cin are ignored unless a transfer-in occurs. A bubble enters stage 0 when in_valid = 0 and advance = 1.
- Results leave strictly in input order. Nothing is dropped or duplicated.

## Timing
- Latency: NSEG cycles from transfer-in to out_valid, with no stalls (4 cycles at defaults).
- Throughput: 1 result per cycle when out_ready is held high.
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, all internal data registers 0. in_ready reads 1 during and after reset.
- Reset asserted mid-operation discards all in-flight operations immediately and asynchronously. The first cycle after rst_n rises behaves as an empty pipeline.
- Simultaneous transfer-in and transfer-out in one cycle is legal and required at full throughput.
- While out_valid = 1 and out_ready = 0, sum, cout and ovf are held stable.
- Full-width carry propagation, e.g. 0xFFFF + 1, is handled across all stages with no extra latency.

## Configuration
- Macro: PIPE_RCA_SAT_EN.
- Defined: if ovf = 1, sum saturates.
  - sum = 2^(WIDTH-1)-1 when both operands are non-negative.
  - sum = -2^(WIDTH-1) when both are negative.
  - cout and ovf still report the raw values.
- Undefined: sum is the raw wrapped result. No saturation logic is present.

## Test plan
All scenarios use WIDTH=16, SEG_W=4.
- Reset: hold rst_n low 3 cycles with in_valid = 1, then release -> out_valid = 0, sum = 0, in_ready = 1. No output until 4 cycles after the first accepted operand.
- Basic add: a=0x00FF, b=0x0001, cin=0 -> 4 cycles later sum=0x0100, cout=0, ovf=0. Also a=0x1234, b=0x1111, cin=1 -> sum=0x2346.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1.
- Overflow:
  - a=0x7FFF, b=0x0001 -> ovf=1, cout=0; sum=0x8000 without the macro, 0x7FFF with it.
  - a=0x8000, b=0xFFFF -> ovf=1, cout=1; sum=0x7FFF without the macro, 0x8000 with it.
- Backpressure: stream 8 consecutive adds (a=i, b=0x0100, cin=0, i=0..7) and drop out_ready for 3 cycles after the 2nd result.
  - in_ready must be 0 for exactly those cycles.
  - The outputs are 0x0100..0x0107 in order, with none lost or repeated.
  - sum is held stable while stalled.
- Reset mid-stream: assert rst_n low while 3 operations are in flight -> out_valid drops immediately, and none of those 3 results ever appear after release.
